// File: rtl/game_round_ctrl.sv
// +--------------------------------------------------------------------------+
// | game_round_ctrl                                                          |
// | Reaction-game round sequencer: prompt, key judgement, scoring, lives.    |
// | Define ROUND_SPEEDUP_EN to shorten the round timer as the level rises.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module game_round_ctrl #(
  parameter int TIMEOUT_BASE  = 1000,
  parameter int TIMEOUT_STEP  = 100,
  parameter int LEVEL_POINTS  = 4,
  parameter int RESULT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       prompt_valid,
  input  logic [1:0] prompt_dir,
  input  logic       prompt_neg,
  input  logic       key_valid,
  input  logic [1:0] key_dir,
  output logic       prompt_req,
  output logic [1:0] result,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic       dead,
  output logic [2:0] state
);

  localparam int c_timer_w = $clog2(TIMEOUT_BASE + 1);
  localparam int c_cnt_w   = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

  localparam logic [c_timer_w-1:0] c_base_m1 = c_timer_w'(TIMEOUT_BASE - 1);
  localparam logic [c_timer_w-1:0] c_step    = c_timer_w'(TIMEOUT_STEP);
  localparam logic [c_cnt_w-1:0]   c_res_last = c_cnt_w'(RESULT_CYCLES - 1);
  localparam logic [7:0]           c_lvl_pts  = 8'(LEVEL_POINTS);

`ifdef ROUND_SPEEDUP_EN
  localparam logic c_speedup_en = 1'b1;
`else
  localparam logic c_speedup_en = 1'b0;
`endif

  localparam logic [1:0] c_res_none    = 2'b00;
  localparam logic [1:0] c_res_hit     = 2'b01;
  localparam logic [1:0] c_res_wrong   = 2'b10;
  localparam logic [1:0] c_res_timeout = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PROMPT   = 3'd1,
    S_WAIT_KEY = 3'd2,
    S_RESULT   = 3'd3,
    S_OVER     = 3'd4
  } state_t;

  state_t               r_state,      w_state_nxt;
  logic [c_timer_w-1:0] r_timer,      w_timer_nxt;
  logic [1:0]           r_dir,        w_dir_nxt;
  logic                 r_neg,        w_neg_nxt;
  logic [1:0]           r_result,     w_result_nxt;
  logic [c_cnt_w-1:0]   r_res_cnt,    w_res_cnt_nxt;
  logic [7:0]           r_score,      w_score_nxt;
  logic [1:0]           r_lives,      w_lives_nxt;
  logic [2:0]           r_level,      w_level_nxt;
  logic                 r_dead,       w_dead_nxt;
  logic                 r_prompt_req, w_prompt_req_nxt;

  logic [c_timer_w-1:0] w_limit_m1;
  logic                 w_correct;
  logic [7:0]           w_score_inc;
  logic                 w_level_up;
  logic [1:0]           w_lives_dec;

  // With the speed-up disabled the level never leaves 0, so the limit stays at the base.
  assign w_limit_m1  = c_base_m1 - (c_timer_w'(r_level) * c_step);
  assign w_correct   = (key_dir == r_dir) ^ r_neg;
  assign w_score_inc = r_score + 8'd1;
  assign w_level_up  = c_speedup_en && ((w_score_inc % c_lvl_pts) == 8'd0) &&
                       (r_level != 3'd7);
  assign w_lives_dec = (r_lives != 2'd0) ? (r_lives - 2'd1) : 2'd0;

  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_dir_nxt        = r_dir;
    w_neg_nxt        = r_neg;
    w_result_nxt     = r_result;
    w_res_cnt_nxt    = r_res_cnt;
    w_score_nxt      = r_score;
    w_lives_nxt      = r_lives;
    w_level_nxt      = r_level;
    w_dead_nxt       = r_dead;
    w_prompt_req_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt      = S_PROMPT;
          w_prompt_req_nxt = 1'b1;
        end
      end

      S_PROMPT: begin
        if (prompt_valid) begin
          w_dir_nxt   = prompt_dir;
          w_neg_nxt   = prompt_neg;
          w_timer_nxt = '0;
          w_state_nxt = S_WAIT_KEY;
        end
      end

      S_WAIT_KEY: begin
        // A key press takes priority over a timer expiring in the same cycle.
        if (key_valid) begin
          w_state_nxt   = S_RESULT;
          w_res_cnt_nxt = '0;
          if (w_correct) begin
            w_result_nxt = c_res_hit;
            if (r_score != 8'hFF) begin
              w_score_nxt = w_score_inc;
              if (w_level_up) begin
                w_level_nxt = r_level + 3'd1;
              end
            end
          end else begin
            w_result_nxt = c_res_wrong;
            w_lives_nxt  = w_lives_dec;
          end
        end else if (r_timer == w_limit_m1) begin
          w_state_nxt   = S_RESULT;
          w_res_cnt_nxt = '0;
          w_result_nxt  = c_res_timeout;
          w_lives_nxt   = w_lives_dec;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      S_RESULT: begin
        if (r_res_cnt == c_res_last) begin
          w_result_nxt = c_res_none;
          if (r_lives == 2'd0) begin
            w_state_nxt = S_OVER;
            w_dead_nxt  = 1'b1;
          end else begin
            w_state_nxt      = S_PROMPT;
            w_prompt_req_nxt = 1'b1;
          end
        end else begin
          w_res_cnt_nxt = r_res_cnt + 1'b1;
        end
      end

      S_OVER: begin
        if (start) begin
          w_score_nxt      = 8'd0;
          w_lives_nxt      = 2'd3;
          w_level_nxt      = 3'd0;
          w_dead_nxt       = 1'b0;
          w_state_nxt      = S_PROMPT;
          w_prompt_req_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_dir        <= 2'd0;
      r_neg        <= 1'b0;
      r_result     <= c_res_none;
      r_res_cnt    <= '0;
      r_score      <= 8'd0;
      r_lives      <= 2'd3;
      r_level      <= 3'd0;
      r_dead       <= 1'b0;
      r_prompt_req <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_dir        <= w_dir_nxt;
      r_neg        <= w_neg_nxt;
      r_result     <= w_result_nxt;
      r_res_cnt    <= w_res_cnt_nxt;
      r_score      <= w_score_nxt;
      r_lives      <= w_lives_nxt;
      r_level      <= w_level_nxt;
      r_dead       <= w_dead_nxt;
      r_prompt_req <= w_prompt_req_nxt;
    end
  end

  assign prompt_req = r_prompt_req;
  assign result     = r_result;
  assign score      = r_score;
  assign lives      = r_lives;
  assign level      = r_level;
  assign dead       = r_dead;
  assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_game_round_ctrl                                                       |
// | Scoreboard bench for game_round_ctrl (BASE=20, STEP=2, PTS=2, HOLD=4).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_game_round_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       prompt_valid;
  logic [1:0] prompt_dir;
  logic       prompt_neg;
  logic       key_valid;
  logic [1:0] key_dir;
  logic       prompt_req;
  logic [1:0] result;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] level;
  logic       dead;
  logic [2:0] state;

  game_round_ctrl #(
    .TIMEOUT_BASE (20),
    .TIMEOUT_STEP (2),
    .LEVEL_POINTS (2),
    .RESULT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .prompt_valid(prompt_valid),
    .prompt_dir  (prompt_dir),
    .prompt_neg  (prompt_neg),
    .key_valid   (key_valid),
    .key_dir     (key_dir),
    .prompt_req  (prompt_req),
    .result      (result),
    .score       (score),
    .lives       (lives),
    .level       (level),
    .dead        (dead),
    .state       (state)
  );

  typedef struct {
    int res;
    int score;
    int lives;
    int level;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   m_score = 0;
  int   m_lives = 3;
  int   m_level = 0;
  int   mon_hold = 0;
  int   mon_prev = 0;
  int   mon_last_lives = 3;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int limit();
`ifdef ROUND_SPEEDUP_EN
    return 20 - m_level * 2;
`else
    return 20;
`endif
  endfunction

  task automatic push_outcome(input bit hit, input int res_code, input int exp_cyc);
    exp_t e;
    if (hit) begin
      if (m_score < 255) begin
        m_score++;
`ifdef ROUND_SPEEDUP_EN
        if ((m_score % 2) == 0 && m_level < 7) m_level++;
`endif
      end
    end else if (m_lives > 0) begin
      m_lives--;
    end
    e.res   = res_code;
    e.score = m_score;
    e.lives = m_lives;
    e.level = m_level;
    e.cyc   = exp_cyc;
    sb.push_back(e);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk_eq({pfx, "_state"}, state, 0);
    chk_eq({pfx, "_score"}, score, 0);
    chk_eq({pfx, "_lives"}, lives, 3);
    chk_eq({pfx, "_level"}, level, 0);
    chk_eq({pfx, "_dead"}, dead, 0);
    chk_eq({pfx, "_result"}, result, 0);
    chk_eq({pfx, "_preq"}, prompt_req, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_prompt_req();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (prompt_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk_eq("prompt_req_seen", seen, 1);
    chk_eq("prompt_state", state, 1);
  endtask

  // key_at < 0 means no key: the round must time out.
  task automatic do_round(input logic [1:0] d, input logic n, input int key_at,
                          input logic [1:0] kd, input bit noise);
    int t_lim;
    int waited;
    bit hit;
    wait_prompt_req();
    prompt_valid = 1'b1;
    prompt_dir   = d;
    prompt_neg   = n;
    if (noise) begin
      key_valid = 1'b1;
      key_dir   = kd;
    end
    @(negedge clk);
    prompt_valid = 1'b0;
    key_valid    = 1'b0;
    chk_eq("wait_state", state, 2);
    t_lim = limit();
    if (key_at >= 0) begin
      waited = 0;
      if (noise) begin
        prompt_valid = 1'b1;
        prompt_dir   = ~d;
        prompt_neg   = n;
        start        = 1'b1;
        @(negedge clk);
        prompt_valid = 1'b0;
        start        = 1'b0;
        chk_eq("noise_state", state, 2);
        waited = 1;
      end
      repeat (key_at - waited) @(negedge clk);
      hit = (kd == d) ^ n;
      push_outcome(hit, hit ? 1 : 2, cyc + 1);
      key_valid = 1'b1;
      key_dir   = kd;
      @(negedge clk);
      key_valid = 1'b0;
    end else begin
      push_outcome(1'b0, 3, cyc + t_lim);
      repeat (t_lim - 1) @(negedge clk);
      chk_eq("pre_timeout_state", state, 2);
      @(negedge clk);
    end
    chk_eq("result_state", state, 3);
  endtask

  // Result monitor: pops the scoreboard on each new result and checks the hold length.
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_hold = 0;
      mon_prev = 0;
    end else begin
      if (result != 2'b00 && mon_prev == 0) begin
        if (sb.size() == 0) begin
          chk_eq("spurious_result", result, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk_eq("result", result, e.res);
          chk_eq("score", score, e.score);
          chk_eq("lives", lives, e.lives);
          chk_eq("level", level, e.level);
          chk_eq("result_cycle", cyc, e.cyc);
          mon_last_lives = e.lives;
        end
        mon_hold = 1;
      end else if (result != 2'b00) begin
        mon_hold++;
      end else if (mon_prev != 0) begin
        chk_eq("result_hold", mon_hold, 4);
        chk_eq("post_result_state", state, (mon_last_lives != 0) ? 1 : 4);
        chk_eq("post_result_preq", prompt_req, (mon_last_lives != 0) ? 1 : 0);
      end
      mon_prev = result;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit over_seen;
    reset_n      = 1'b0;
    start        = 1'b0;
    prompt_valid = 1'b0;
    prompt_dir   = 2'd0;
    prompt_neg   = 1'b0;
    key_valid    = 1'b0;
    key_dir      = 2'd0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("idle_hold_state", state, 0);
    chk_eq("idle_hold_preq", prompt_req, 0);

    pulse_start();
    do_round(2'd1, 1'b0, 3, 2'd1, 1'b0);
    do_round(2'd2, 1'b1, 2, 2'd2, 1'b0);
    do_round(2'd2, 1'b1, 5, 2'd0, 1'b0);
    do_round(2'd3, 1'b0, 4, 2'd3, 1'b1);
    do_round(2'd0, 1'b0, -1, 2'd0, 1'b0);
    do_round(2'd0, 1'b0, limit() - 1, 2'd0, 1'b0);
    do_round(2'd1, 1'b0, 1, 2'd2, 1'b0);

    over_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state == 3'd4) begin
        over_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk_eq("over_reached", over_seen, 1);
    chk_eq("over_dead", dead, 1);
    key_valid    = 1'b1;
    prompt_valid = 1'b1;
    @(negedge clk);
    key_valid    = 1'b0;
    prompt_valid = 1'b0;
    chk_eq("over_ignore_state", state, 4);
    chk_eq("over_ignore_preq", prompt_req, 0);

    pulse_start();
    m_score = 0;
    m_lives = 3;
    m_level = 0;
    chk_eq("restart_state", state, 1);
    chk_eq("restart_score", score, 0);
    chk_eq("restart_lives", lives, 3);
    chk_eq("restart_level", level, 0);
    chk_eq("restart_dead", dead, 0);
    chk_eq("restart_preq", prompt_req, 1);
    do_round(2'd1, 1'b1, 0, 2'd0, 1'b0);

    wait_prompt_req();
    prompt_valid = 1'b1;
    prompt_dir   = 2'd2;
    @(negedge clk);
    prompt_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midrst");
    m_score = 0;
    m_lives = 3;
    m_level = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("post_rst_idle", state, 0);
    pulse_start();
    do_round(2'd2, 1'b0, 1, 2'd2, 1'b0);

    repeat (8) @(negedge clk);
    chk_eq("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
